// File: rtl/sparse_pkg.sv
// Shared sparse-datapath defaults used by simple_cu and sparse_row_acc.
// d_entry_t describes one output FIFO entry at the default widths.
package sparse_pkg;

    localparam int DW_DATA   = 8;
    localparam int DW_ROWIDX = 4;
    localparam int DW_ELEIDX = 4;
    localparam int DW_ACC    = 24;
    localparam int OUT_DEPTH = 2;

    typedef struct packed {
        logic [DW_ROWIDX-1:0] row;
        logic [DW_ACC-1:0]    data;
    } d_entry_t;

endpackage

// File: rtl/sparse_row_fifo.sv
// Small synchronous FIFO with a registered head entry, registered full flag,
// and occupancy count. A pop and a push may share a cycle at any occupancy,
// including full, so the push is accepted when a pop frees the slot.
module sparse_row_fifo
    import sparse_pkg::*;
#(
    parameter int DEPTH = OUT_DEPTH,
    parameter int W     = DW_ROWIDX + DW_ACC
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    // Next pointers, count and head; the head is reloaded from the new read slot,
    // bypassing the incoming word when it lands in that very slot.
    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        head_d  = head_q;
        if (cnt_d != '0) begin
            head_d = (do_push && (wr_q == rd_d)) ? push_data : mem_q[rd_d];
        end
    end

    // Control state and head register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == CW'(DEPTH));
            head_q <= head_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign empty = (cnt_q == '0);
    assign full  = full_q;
    assign count = cnt_q;

endmodule

// File: rtl/sparse_row_acc.sv
// Row accumulator for the sparse datapath: sums signed PE products per row and
// pushes {row, sum} into a small output FIFO on each row close.
// Build option: SPARSE_ROW_ACC_SAT_EN selects signed-saturating accumulation
// (sticky clamp until the row closes); otherwise the sum wraps at DW_ACC bits.
module sparse_row_acc #(
    parameter int DW_DATA   = sparse_pkg::DW_DATA,
    parameter int DW_ROWIDX = sparse_pkg::DW_ROWIDX,
    parameter int DW_ACC    = sparse_pkg::DW_ACC,
    parameter int OUT_DEPTH = sparse_pkg::OUT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2*DW_DATA-1:0]   prod_in,
    input  logic                   acc_en,
    input  logic                   out_valid,
    input  logic [DW_ROWIDX-1:0]   row,
    output logic                   D_valid,
    input  logic                   D_ready,
    output logic [DW_ROWIDX-1:0]   D_row,
    output logic [DW_ACC-1:0]      D_data,
    output logic                   full,
    output logic                   ovf
);

    localparam int EW = DW_ROWIDX + DW_ACC;

    logic signed [DW_ACC-1:0] acc_q, acc_d;
    logic signed [DW_ACC-1:0] prod_ext;
    logic signed [DW_ACC-1:0] row_sum;
    logic                     ovf_q;
    logic                     pop;
    logic                     fifo_empty;
    logic [$clog2(OUT_DEPTH):0] fifo_count;
    logic [EW-1:0]            head;

    assign prod_ext = DW_ACC'(signed'(prod_in));
    assign pop      = (fifo_count != '0) && D_ready;

`ifdef SPARSE_ROW_ACC_SAT_EN
    localparam logic signed [DW_ACC-1:0] ACC_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
    localparam logic signed [DW_ACC-1:0] ACC_MIN = {1'b1, {(DW_ACC-1){1'b0}}};

    logic sat_q, sat_d;

    function automatic logic add_overflows(input logic signed [DW_ACC-1:0] a,
                                           input logic signed [DW_ACC-1:0] b);
        logic signed [DW_ACC-1:0] s;
        s = a + b;
        return (a[DW_ACC-1] == b[DW_ACC-1]) && (s[DW_ACC-1] != a[DW_ACC-1]);
    endfunction

    function automatic logic signed [DW_ACC-1:0] sat_add(input logic signed [DW_ACC-1:0] a,
                                                         input logic signed [DW_ACC-1:0] b);
        if (add_overflows(a, b)) begin
            return a[DW_ACC-1] ? ACC_MIN : ACC_MAX;
        end
        return a + b;
    endfunction

    // Saturating row sum; once clamped, further products are ignored until close.
    always_comb begin
        row_sum = acc_q;
        sat_d   = sat_q;
        if (acc_en && !sat_q) begin
            row_sum = sat_add(acc_q, prod_ext);
            sat_d   = add_overflows(acc_q, prod_ext);
        end
        if (out_valid) begin
            sat_d = 1'b0;
        end
    end

    // Clamp-held flag for the current row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    // Wrapping row sum; a same-cycle product belongs to the row being closed.
    always_comb begin
        row_sum = acc_en ? (acc_q + prod_ext) : acc_q;
    end
`endif

    // Accumulator clears on every row close, whether or not the push was kept.
    always_comb begin
        acc_d = out_valid ? '0 : row_sum;
    end

    // Accumulator and sticky overflow flag for dropped row closes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (out_valid && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sparse_row_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (out_valid),
        .push_data ({row, row_sum}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (full),
        .count     (fifo_count)
    );

    assign D_valid = !fifo_empty;
    assign D_row   = head[EW-1:DW_ACC];
    assign D_data  = head[DW_ACC-1:0];
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_sparse_row_acc.sv
// Bench for sparse_row_acc: directed scenarios plus a random stream, all
// compared cycle by cycle against a queue-based reference model.
module tb_sparse_row_acc;

    localparam int DEP = 2;
    localparam longint AMAX = 64'sd8388607;
    localparam longint AMIN = -64'sd8388608;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [15:0]        prod_in;
    logic               acc_en, out_valid, D_ready;
    logic [3:0]         row;
    logic               D_valid, full, ovf;
    logic [3:0]         D_row;
    logic [23:0]        D_data;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct { int r; longint d; } ent_t;
    ent_t   mq[$];
    longint m_acc;
    bit     m_sat, m_ovf;

    always #5 clk = ~clk;

    sparse_row_acc #(
        .DW_DATA(8), .DW_ROWIDX(4), .DW_ACC(24), .OUT_DEPTH(DEP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .prod_in(prod_in), .acc_en(acc_en),
        .out_valid(out_valid), .row(row), .D_valid(D_valid), .D_ready(D_ready),
        .D_row(D_row), .D_data(D_data), .full(full), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic longint wrap24(input longint v);
        longint t;
        t = v & 64'hFFFFFF;
        if (t >= 64'sd8388608) t = t - 64'sd16777216;
        return t;
    endfunction

    function automatic logic [31:0] as24(input longint v);
        longint t;
        t = v & 64'hFFFFFF;
        return t[31:0];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_D_valid"}, {31'b0, D_valid}, {31'b0, mq.size() != 0});
        chk({tag, "_full"},    {31'b0, full},    {31'b0, mq.size() == DEP});
        chk({tag, "_ovf"},     {31'b0, ovf},     {31'b0, m_ovf});
        if (mq.size() != 0) begin
            chk({tag, "_D_row"},  {28'b0, D_row},  mq[0].r);
            chk({tag, "_D_data"}, {8'b0, D_data},  as24(mq[0].d));
        end
    endtask

    task automatic step(input bit en, input int p, input bit ov, input int r, input bit rdy,
                        input string tag);
        longint raw, sum;
        bit     clamp, popped;
        @(negedge clk);
        acc_en = en; prod_in = p[15:0]; out_valid = ov; row = r[3:0]; D_ready = rdy;
        @(posedge clk);
        #1;
        sum = m_acc; clamp = 1'b0;
        if (en) begin
`ifdef SPARSE_ROW_ACC_SAT_EN
            if (!m_sat) begin
                raw = m_acc + longint'(p);
                if (raw > AMAX) begin sum = AMAX; clamp = 1'b1; end
                else if (raw < AMIN) begin sum = AMIN; clamp = 1'b1; end
                else sum = raw;
            end
`else
            raw = m_acc + longint'(p);
            sum = wrap24(raw);
`endif
        end
        popped = (mq.size() != 0) && rdy;
        if (popped) void'(mq.pop_front());
        if (ov) begin
            if (mq.size() < DEP) mq.push_back('{r: r, d: sum});
            else m_ovf = 1'b1;
            m_acc = 0; m_sat = 1'b0;
        end else begin
            m_acc = sum; m_sat = m_sat | clamp;
        end
        check_model(tag);
    endtask

    task automatic chk_head(input string tag, input int r, input longint d);
        chk({tag, "_row"},  {28'b0, D_row}, r);
        chk({tag, "_data"}, {8'b0, D_data}, as24(d));
    endtask

    task automatic reset_now(input string tag);
        reset_n = 1'b0;
        acc_en = 1'b0; out_valid = 1'b0; D_ready = 1'b0; prod_in = '0; row = '0;
        mq.delete(); m_acc = 0; m_sat = 1'b0; m_ovf = 1'b0;
        #1;
        chk({tag, "_D_valid"}, {31'b0, D_valid}, 0);
        chk({tag, "_D_row"},   {28'b0, D_row},   0);
        chk({tag, "_D_data"},  {8'b0, D_data},   0);
        chk({tag, "_full"},    {31'b0, full},    0);
        chk({tag, "_ovf"},     {31'b0, ovf},     0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] rp;
        longint sat_exp;
        reset_n = 1'b1;
        acc_en = 1'b0; out_valid = 1'b0; D_ready = 1'b0; prod_in = '0; row = '0;
        #2;
        reset_now("rst0");

        // Rowptr {0,2,3,3,3,6,6,7}: rows 0..6, D_ready held high.
        step(1, 3, 0, 0, 1, "r0a");
        step(1, 4, 1, 0, 1, "r0b");   chk_head("seq_r0", 0, 7);
        step(1, -5, 0, 1, 1, "r1a");
        step(0, 0, 1, 1, 1, "r1b");   chk_head("seq_r1", 1, -5);
        step(0, 0, 1, 2, 1, "r2");    chk_head("seq_r2", 2, 0);
        step(0, 0, 1, 3, 1, "r3");    chk_head("seq_r3", 3, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4, 1, "r4a");
        step(0, 0, 1, 4, 1, "r4b");   chk_head("seq_r4", 4, 3);
        step(0, 0, 1, 5, 1, "r5");    chk_head("seq_r5", 5, 0);
        step(1, 7, 1, 6, 1, "r6");    chk_head("seq_r6", 6, 7);
        step(0, 0, 0, 0, 1, "idle");

        // Same-cycle product and close.
        step(1, 10, 0, 1, 1, "sc_a");
        step(1, 5, 1, 1, 1, "sc_b");  chk_head("same_cyc", 1, 15);
        step(0, 0, 1, 2, 1, "sc_c");  chk_head("next_row0", 2, 0);
        step(0, 0, 0, 0, 1, "sc_d");

        // Back-pressure: third close is dropped, head holds.
        reset_now("rst1");
        step(1, 1, 1, 1, 0, "bp1");
        step(1, 2, 1, 2, 0, "bp2");   chk("bp_full", {31'b0, full}, 1);
        step(1, 3, 1, 3, 0, "bp3");   chk("bp_ovf", {31'b0, ovf}, 1);
        step(0, 0, 0, 0, 0, "bp4");   chk_head("bp_stable", 1, 1);
        step(0, 0, 0, 0, 1, "bp5");   chk_head("bp_next", 2, 2);
        step(0, 0, 0, 0, 1, "bp6");

        // Full with simultaneous pop and push.
        reset_now("rst2");
        step(1, 1, 1, 1, 0, "fp1");
        step(1, 2, 1, 2, 0, "fp2");
        step(1, 9, 1, 5, 1, "fp3");
        chk("fp_full", {31'b0, full}, 1);
        chk("fp_noovf", {31'b0, ovf}, 0);
        chk_head("fp_head", 2, 2);
        step(0, 0, 0, 0, 1, "fp4");   chk_head("fp_tail", 5, 9);
        step(0, 0, 0, 0, 1, "fp5");

        // Large accumulation past 2^23-1.
        for (int i = 0; i < 530; i++) step(1, 16129, 0, 7, 1, "big");
        step(0, 0, 1, 7, 1, "big_close");
`ifdef SPARSE_ROW_ACC_SAT_EN
        sat_exp = 8388607;
`else
        sat_exp = 8548370;
`endif
        chk_head("big_sum", 7, sat_exp);
        step(0, 0, 0, 0, 1, "big_idle");

        // Reset mid-row after two products.
        step(1, 4, 0, 3, 1, "mr1");
        step(1, 5, 0, 3, 1, "mr2");
        @(negedge clk);
        #2;
        reset_now("rst_mid");
        step(1, 6, 1, 3, 1, "mr3");   chk_head("mid_excl", 3, 6);

        // Random stream.
        for (int i = 0; i < 400; i++) begin
            rp = 16'($urandom);
            step(1'($urandom_range(0, 1)), int'($signed(rp)), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sparse_row_acc.md
# sparse_row_acc

Downstream neighbour of `simple_cu` in the unstructured sparse datapath. Consumes the per-cycle PE product stream qualified by the CU's `acc_en` / `out_valid` / `row` control. Accumulates products into one running row sum and, on each row close, pushes `{row, sum}` into a small output FIFO. The FIFO drains to the D writer over a valid/ready handshake.

## Interface
Parameters:
- `DW_DATA`, 8: operand width; products are `2*DW_DATA` bits, signed.
- `DW_ROWIDX`, 4: row index width, matches the CU.
- `DW_ACC`, 24: accumulator and output data width; must be ≥ `2*DW_DATA`.
- `OUT_DEPTH`, 2: output FIFO depth; power of two, ≥ 2.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `prod_in` in `2*DW_DATA`: signed product from the PE, valid when `acc_en`=1.
- `acc_en` in 1: add `prod_in` into the accumulator this cycle.
- `out_valid` in 1: close the current row this cycle.
- `row` in `DW_ROWIDX`: row index of the row being closed; sampled when `out_valid`=1.
- `D_valid` out 1: output FIFO non-empty.
- `D_ready` in 1: downstream accepts the FIFO head.
- `D_row` out `DW_ROWIDX`: row index of the FIFO head.
- `D_data` out `DW_ACC`: row sum at the FIFO head.
- `full` out 1: FIFO full; advisory stall for the CU.
- `ovf` out 1: sticky flag, set when a row close is dropped.

## Operation
- `prod_in` is sign-extended to `DW_ACC` before it is added.
- Accumulator update, one of four cases each cycle:
  - `acc_en`=1, `out_valid`=0: `acc <= acc + prod_in`.
  - `acc_en`=0, `out_valid`=1: push `{row, acc}`, then `acc <= 0`.
  - `acc_en`=1, `out_valid`=1: push `{row, acc + prod_in}`, then `acc <= 0`. The same-cycle product belongs to the closing row.
  - Neither asserted: `acc` holds.
- Empty row (a close with no prior `acc_en` since the last close): pushes sum 0. This is mandatory, so every row index reaches D.
- FIFO push and pop:
  - A push occurs on `out_valid` while `full`=0.
  - A pop occurs on `D_valid && D_ready`.
  - Push and pop in the same cycle are both allowed at any occupancy, including full. When full, a simultaneous pop frees the slot and the push is accepted.
- Overflow: `out_valid` while `full`=1 with no same-cycle pop drops the push and sets `ovf`. The accumulator still clears. `ovf` clears only on reset.
- FIFO is in-order. Its pointers wrap modulo `OUT_DEPTH`, and the count is `log2(OUT_DEPTH)+1` bits.

## Timing
- Reset values: `acc`=0, FIFO empty, `D_valid`=0, `D_row`=0, `D_data`=0, `full`=0, `ovf`=0. Reset asserted mid-row discards the partial sum and all FIFO contents.
- Latency: row close at edge N gives `D_valid`=1 after edge N, i.e. visible in the cycle following the close, with the FIFO previously empty.
- `D_row` and `D_data` are FIFO head registers. They are stable while `D_valid`=1 and `D_ready`=0.
- `full` is registered and reflects occupancy after the current edge. It is combinationally independent of `D_ready`.
- Throughput: one row close per cycle sustained while `D_ready`=1.

## Configuration
- `SPARSE_ROW_ACC_SAT_EN` defined: accumulation is signed-saturating. On overflow, `acc` clamps to `2^(DW_ACC-1)-1` or `-2^(DW_ACC-1)` and stays clamped until the row closes.
- Undefined: plain two's-complement wrap-around at `DW_ACC` bits.

## Structure
- `sparse_pkg` package holds `DW_DATA`, `DW_ROWIDX`, `DW_ELEIDX` defaults shared with `simple_cu`, plus a `d_entry_t` packed struct `{row, data}`.
- One sub-module: `sparse_row_fifo`, a synchronous FIFO with depth `OUT_DEPTH`, registered head, and `full`/`empty`/count.
- Accumulator and saturation logic stay in the top level.

## Test plan
- Rowptr `{0,2,3,3,3,6,6,7}`, products row0 {3,4}, row1 {-5}, row4 {1,1,1}, row6 {7}, `D_ready`=1. Expect D sequence (0,7), (1,-5), (2,0), (3,0), (4,3), (5,0), (6,7).
- `acc_en` and `out_valid` in the same cycle with prior acc 10 and `prod_in`=5. Expect pushed sum 15, and the next row starts at 0.
- Hold `D_ready`=0 and close 3 rows with depth 2. Expect `full`=1 after the 2nd close, the 3rd close dropped, `ovf`=1, and the head stable at the first row.
- With the FIFO full, assert `D_ready`=1 and `out_valid` in the same cycle. Expect the push accepted, no `ovf`, and count still 2.
- Add 127·127 repeatedly past `2^23-1`. With `SPARSE_ROW_ACC_SAT_EN`, expect `D_data`=8388607. Without it, expect the wrapped value.
- Assert `reset_n` low mid-row after 2 products. Expect all outputs 0 immediately, and the next row sum to exclude the earlier products.
